timer_counter: RTL and testbench



---
 rtl/timer_counter_pkg.sv | 38 +++
 rtl/timer_counter.sv | 143 ++++++++++++++
 tb/tb_timer_counter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field layout, mode codes and FSM state encodings.
package timer_counter_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Packed so that bit 0 = EN, bits [2:1] = MODE, bit 3 = IM.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {28'd0, c};
  endfunction

  function automatic ctrl_t word_to_ctrl(input logic [3:0] w);
    return ctrl_t'(w);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Programmable countdown timer on the CPU data bus with one-shot and
// auto-reload modes and a registered, maskable interrupt request.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;

  logic        hit_s;
  logic        wr_s;
  logic        ctrl_wr_s;
  logic        preset_wr_s;
  logic [3:0]  off_s;
  logic        fsm_en_clr_s;
  logic        fsm_pend_set_s;
  logic        fsm_pend_clr_s;
  logic        unused_addr_s;

  assign off_s         = {addr[3:2], 2'b00};
  assign hit_s         = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
  assign wr_s          = hit_s && (byteen == 4'b1111);
  assign ctrl_wr_s     = wr_s && (off_s == OFF_CTRL);
  assign preset_wr_s   = wr_s && (off_s == OFF_PRESET);
  assign unused_addr_s = ^addr[1:0];

  always_comb begin
    rdata = 32'd0;
    if (hit_s) begin
      case (off_s)
        OFF_CTRL:   rdata = ctrl_to_word(ctrl_q);
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    fsm_en_clr_s   = 1'b0;
    fsm_pend_set_s = 1'b0;
    fsm_pend_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // Disabling mid-count parks the FSM with COUNT frozen.
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          count_d        = 32'd0;
          fsm_pend_set_s = 1'b1;
          state_d        = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          fsm_pend_clr_s = 1'b1;
          state_d        = ST_LOAD;
        end else begin
          fsm_en_clr_s = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A CTRL bus write overrides any same-edge FSM update of EN or pending.
  always_comb begin
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    if (ctrl_wr_s) begin
      ctrl_d    = word_to_ctrl(wdata[3:0]);
      pending_d = 1'b0;
    end else begin
      if (fsm_en_clr_s) begin
        ctrl_d.en = 1'b0;
      end else begin
        ctrl_d.en = ctrl_q.en;
      end
      if (fsm_pend_set_s) begin
        pending_d = 1'b1;
      end else if (fsm_pend_clr_s) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end
    preset_d = preset_wr_s ? wdata : preset_q;
    irq_d    = pending_d & ctrl_d.im;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations are queued as stimulus is
// driven and popped when the DUT output is sampled just after the clock edge.
module tb_timer_counter;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;
  localparam logic [3:0]  BE_ALL = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   ar_cnt[5] = '{3, 2, 1, 0, 0};

  always #5 clk = ~clk;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_underflow observed %h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    push_exp(tag, exp);
    addr = a;
    #1;
    compare(rdata);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    push_exp(tag, {31'd0, exp});
    compare({31'd0, irq});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_irq;
    reset  = 1'b1;
    addr   = 32'd0;
    wdata  = 32'd0;
    byteen = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    rd("init_ctrl", A_CTRL, 32'h0);
    rd("init_count", A_CNT, 32'h0);
    chk_irq("init_irq", 1'b0);

    // Reset asserted mid-count with COUNT = 3
    wr(A_PRE, 32'd3, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    tick();
    tick();
    rd("mid_count", A_CNT, 32'd3);
    #1;
    reset = 1'b1;
    #1;
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_preset", A_PRE, 32'h0);
    rd("rst_count", A_CNT, 32'h0);
    chk_irq("rst_irq", 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    rd("post_rst_ctrl", A_CTRL, 32'h0);
    rd("post_rst_count", A_CNT, 32'h0);
    chk_irq("post_rst_irq", 1'b0);

    // One-shot, PRESET = 5
    wr(A_PRE, 32'd5, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    tick();
    chk_irq("os_irq_t1", 1'b0);
    tick();
    for (int k = 5; k >= 0; k--) begin
      rd("os_count", A_CNT, 32'(k));
      chk_irq("os_irq", (k == 0));
      tick();
    end
    rd("os_ctrl_after_int", A_CTRL, 32'h8);
    chk_irq("os_irq_held", 1'b1);
    tick();
    tick();
    chk_irq("os_irq_held2", 1'b1);
    wr(A_CTRL, 32'h8, BE_ALL);
    chk_irq("os_irq_cleared", 1'b0);
    rd("os_ctrl_rewritten", A_CTRL, 32'h8);

    // Auto-reload, PRESET = 3: pulses after t5, t10, t15
    wr(A_PRE, 32'd3, BE_ALL);
    wr(A_CTRL, 32'hB, BE_ALL);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
      chk_irq("ar_irq", exp_irq);
      if (k >= 2) begin
        rd("ar_count", A_CNT, 32'(ar_cnt[(k - 2) % 5]));
      end
    end
    wr(A_CTRL, 32'h0, BE_ALL);
    repeat (3) tick();
    chk_irq("ar_stopped_irq", 1'b0);

    // PRESET = 0 interrupts after t3
    wr(A_PRE, 32'd0, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    tick();
    chk_irq("p0_irq_t1", 1'b0);
    tick();
    chk_irq("p0_irq_t2", 1'b0);
    tick();
    chk_irq("p0_irq_t3", 1'b1);
    wr(A_CTRL, 32'h0, BE_ALL);
    chk_irq("p0_irq_clr", 1'b0);
    tick();

    // IM = 0: count completes, irq stays low
    wr(A_PRE, 32'd2, BE_ALL);
    wr(A_CTRL, 32'h1, BE_ALL);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_irq("mask_irq", 1'b0);
      if (k == 2) begin
        rd("mask_count_start", A_CNT, 32'd2);
      end
    end
    rd("mask_ctrl_en_clr", A_CTRL, 32'h0);
    rd("mask_count_done", A_CNT, 32'h0);

    // Bus corner cases
    wr(A_PRE, 32'h55, 4'b0011);
    rd("partial_wr_preset", A_PRE, 32'd2);
    wr(A_CNT, 32'h1234, BE_ALL);
    rd("count_wr_ignored", A_CNT, 32'h0);
    rd("rsv_read", A_RSV, 32'h0);
    rd("miss_read_above", BASE + 32'h14, 32'h0);
    rd("miss_read_far", 32'h0000_8F04, 32'h0);
    wr(32'h0000_8F04, 32'h9, BE_ALL);
    rd("miss_wr_preset", A_PRE, 32'd2);

    // Clearing EN mid-count freezes COUNT
    wr(A_PRE, 32'd10, BE_ALL);
    wr(A_CTRL, 32'h1, BE_ALL);
    tick();
    tick();
    rd("frz_count_t2", A_CNT, 32'd10);
    tick();
    tick();
    rd("frz_count_t4", A_CNT, 32'd8);
    wr(A_CTRL, 32'h0, BE_ALL);
    rd("frz_count_t5", A_CNT, 32'd7);
    tick();
    rd("frz_count_t6", A_CNT, 32'd7);
    repeat (3) tick();
    rd("frz_count_t9", A_CNT, 32'd7);
    rd("frz_ctrl", A_CTRL, 32'h0);

    // CTRL write on the edge the FSM enters INT
    wr(A_PRE, 32'd2, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    tick();
    tick();
    tick();
    wr(A_CTRL, 32'h9, BE_ALL);
    rd("col_ctrl", A_CTRL, 32'h9);
    chk_irq("col_irq", 1'b0);
    rd("col_count", A_CNT, 32'h0);
    tick();
    rd("col_ctrl_t5", A_CTRL, 32'h8);
    chk_irq("col_irq_t5", 1'b0);

    n_total++;
    assert (sb_q.size() == 0) n_pass++;
    else $error("FAIL sb_leftover observed %0d expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
